output_shift_register: RTL and testbench

OUTPUT_SHIFT_REGISTER -- requirements
Module: output_shift_register

---
 rtl/output_shift_register.sv | 133 +++++++++++++
 tb/tb_output_shift_register.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/output_shift_register.sv
// Serialises a parallel word MSB first with a generated bit clock and push strobe.
// Define OUTPUT_PARITY_EN to append an even-parity bit after the LSB.
module output_shift_register #(
  parameter int numOutputs = 8,
  parameter int dataWidth  = 4,
  parameter int clkDiv     = 4
) (
  input  logic                               CLOCK_50,
  input  logic                               reset,
  input  logic [numOutputs*dataWidth-1:0]    dataIn,
  input  logic                               load,
  output logic                               serialClock,
  output logic                               serialData,
  output logic                               busy,
  output logic                               pushBuffer
);

  localparam int W  = numOutputs * dataWidth;
`ifdef OUTPUT_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif
  localparam int BW = $clog2(W + 2);
  localparam int PW = (clkDiv > 1) ? $clog2(clkDiv) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(clkDiv - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PUSH
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FB-1:0] shreg_q, shreg_d;
  logic          sclk_q, sclk_d;
  logic          sdat_q, sdat_d;
  logic          busy_q, busy_d;
  logic          push_q, push_d;
  logic [FB-1:0] frame;

`ifdef OUTPUT_PARITY_EN
  assign frame = {dataIn, ^dataIn};
`else
  assign frame = dataIn;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    sdat_d  = sdat_q;
    busy_d  = busy_q;
    push_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          shreg_d = frame;
          sdat_d  = frame[FB-1];
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            state_d = PUSH;
            sclk_d  = 1'b0;
            sdat_d  = 1'b0;
            push_d  = 1'b1;
            bit_d   = '0;
            shreg_d = '0;
          end else begin
            // data moves only on the falling bit-clock edge
            sclk_d  = 1'b0;
            bit_d   = bit_q + 1'b1;
            sdat_d  = shreg_q[FB-2];
            shreg_d = {shreg_q[FB-2:0], shreg_q[FB-1]};
          end
        end
      end
      PUSH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      busy_q  <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      busy_q  <= busy_d;
      push_q  <= push_d;
    end
  end

  assign serialClock = sclk_q;
  assign serialData  = sdat_q;
  assign busy        = busy_q;
  assign pushBuffer  = push_q;

endmodule

// File: tb/tb_output_shift_register.sv
// Bench for output_shift_register: scoreboard of serial bits and frame timing.
module tb_output_shift_register;

  localparam int W  = 32;
  localparam int CD = 4;
`ifdef OUTPUT_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         rst1_n = 1'b0;
  logic         ld     = 1'b0;
  logic         ld1    = 1'b0;
  logic [W-1:0] din    = '0;
  logic [W-1:0] din1   = 32'hF0F0_1234;
  logic         sclk, sdat, busy, push;
  logic         sclk1, sdat1, busy1, push1;

  always #5 clk = ~clk;

  output_shift_register u_dut (
    .CLOCK_50    (clk),
    .reset       (rst_n),
    .dataIn      (din),
    .load        (ld),
    .serialClock (sclk),
    .serialData  (sdat),
    .busy        (busy),
    .pushBuffer  (push)
  );

  output_shift_register #(.clkDiv(1)) u_fast (
    .CLOCK_50    (clk),
    .reset       (rst1_n),
    .dataIn      (din1),
    .load        (ld1),
    .serialClock (sclk1),
    .serialData  (sdat1),
    .busy        (busy1),
    .pushBuffer  (push1)
  );

  int   n_cmp  = 0;
  int   n_err  = 0;
  int   rises  = 0;
  int   pushes = 0;
  bit   exp_q[$];
  time  p1_t[$];
  time  push_t = 0;
  time  lt     = 0;
  time  t1     = 0;
  logic sclk_prev = 1'b0;
  logic sdat_prev = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic queue_frame(logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (FB > W) exp_q.push_back(^d);
  endtask

  always @(negedge clk) begin
    if (sclk && !sclk_prev) begin
      rises++;
      chk("bit_stable", 32'(sdat), 32'(sdat_prev));
      chk("bit_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("bit", 32'(sdat), 32'(exp_q.pop_front()));
    end
    sclk_prev = sclk;
    sdat_prev = sdat;
    if (push) begin
      pushes++;
      push_t = $time;
    end
    if (push1) p1_t.push_back($time);
  end

  task automatic send(logic [W-1:0] d);
    din = d;
    ld  = 1'b1;
    queue_frame(d);
    @(posedge clk);
    lt = $time;
    step();
    chk("busy_on", 32'(busy), 1);
    chk("sclk_low_start", 32'(sclk), 0);
    chk("first_bit", 32'(sdat), 32'(d[W-1]));
    ld = 1'b0;
  endtask

  task automatic finish_frame(int p0);
    int k = 0;
    while (pushes == p0 && k < 600) begin
      step();
      k++;
    end
    chk("push_seen", 32'(pushes - p0), 1);
    chk("push_cycle", 32'(int'((push_t - lt - 5) / 10)), 32'(FB * 2 * CD));
    chk("push_outs", {28'd0, sclk, sdat, busy, push}, 32'b0011);
    step();
    chk("idle_outs", {28'd0, sclk, sdat, busy, push}, 32'b0000);
    chk("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int r0;
    int p0;
    int k;
    repeat (3) step();
    chk("rst_outs", {28'd0, sclk, sdat, busy, push}, 0);
    chk("rst_outs_fast", {28'd0, sclk1, sdat1, busy1, push1}, 0);

    rst_n  = 1'b1;
    rst1_n = 1'b1;
    ld1    = 1'b1;
    p0     = pushes;
    send(32'h6E4A_5A5B);
    t1 = lt;
    ld  = 1'b1;
    din = 32'h1111_2222;
    repeat (20) step();
    ld  = 1'b0;
    finish_frame(p0);

    p0 = pushes;
    send(32'hA5C3_0F96);
    r0 = rises;
    k  = 0;
    while (rises < r0 + 10 && k < 300) begin
      step();
      k++;
    end
    chk("reach_bit10", 32'(rises - r0), 10);
    rst_n = 1'b0;
    ld    = 1'b1;
    step();
    chk("abort_outs", {28'd0, sclk, sdat, busy, push}, 0);
    exp_q.delete();
    step();
    chk("load_ignored_in_reset", 32'(busy), 0);
    ld    = 1'b0;
    rst_n = 1'b1;
    repeat (300) step();
    chk("no_push_on_abort", 32'(pushes), 32'(p0));

    p0 = pushes;
    send(32'h0123_4567);
    finish_frame(p0);

    p0 = pushes;
    send(32'h0000_0001);
    finish_frame(p0);

    chk("fast_push_count", 32'(p1_t.size() >= 4), 1);
    if (p1_t.size() >= 4) begin
      chk("fast_first_push", 32'(int'((p1_t[0] - t1 - 5) / 10)), 32'(FB * 2));
      for (int i = 0; i < 3; i++)
        chk("fast_period", 32'(int'((p1_t[i+1] - p1_t[i]) / 10)), 32'(FB * 2 + 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
